// File: rtl/msg_slot_scheduler_pkg.sv
// Shared types and defaults for the message slot scheduler.
package msg_slot_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OFFER  = 2'd1,
      ST_GAP    = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   localparam int DEF_NUM_SLOTS = 5;
   localparam int DEF_IDX_W     = 3;
   localparam int DEF_TICK_DIV  = 2;
   localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/msg_slot_scheduler_slot_pick.sv
// Finds the lowest enabled slot at or above (include_base=1) or strictly above
// (include_base=0) a base index. Purely combinational.
module msg_slot_scheduler_slot_pick
   import msg_slot_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int IDX_W     = DEF_IDX_W
) (
   input  logic [NUM_SLOTS-1:0] mask,
   input  logic [IDX_W-1:0]     base,
   input  logic                 include_base,
   output logic                 found,
   output logic [IDX_W-1:0]     idx
);

   // Scan from the top down so the last qualifying hit is the lowest index.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (mask[i] && ((i > int'(base)) || (include_base && (i == int'(base))))) begin
            found = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/msg_slot_scheduler.sv
// Orders enabled message slots onto a single sink with a fixed idle gap
// between a completed handshake and the next offer.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; mask/loop captured when start arrives
// ST_OFFER  | out_valid high with out_idx = cursor until the sink accepts
// ST_GAP    | out_valid low for TICK_DIV cycles before the next offer
// ST_FINISH | one-cycle done pulse, then back to idle
module msg_slot_scheduler
   import msg_slot_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int IDX_W     = DEF_IDX_W,
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 loop,
   input  logic [NUM_SLOTS-1:0] slot_en,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [IDX_W-1:0]     out_idx,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     issued_cnt
);

   localparam int GAP_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TICK_DIV - 1);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       cursor_q, cursor_d;
   logic [NUM_SLOTS-1:0]   mask_q, mask_d;
   logic                   loop_q, loop_d;
   logic [GAP_W-1:0]       gap_q, gap_d;
   logic [CNT_W-1:0]       issued_q, issued_d;

   logic [NUM_SLOTS-1:0]   first_mask;
   logic                   first_found;
   logic [IDX_W-1:0]       first_idx;
   logic                   next_found;
   logic [IDX_W-1:0]       next_idx;
   logic                   hs;

   // In IDLE the first slot comes straight from the live enable mask so the
   // offer appears the cycle after start; afterwards only the captured mask counts.
   assign first_mask = (state_q == ST_IDLE) ? slot_en : mask_q;

   msg_slot_scheduler_slot_pick #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) u_pick_first (
      .mask         (first_mask),
      .base         ('0),
      .include_base (1'b1),
      .found        (first_found),
      .idx          (first_idx)
   );

   msg_slot_scheduler_slot_pick #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) u_pick_next (
      .mask         (mask_q),
      .base         (cursor_q),
      .include_base (1'b0),
      .found        (next_found),
      .idx          (next_idx)
   );

   // State register plus cursor, captured mask/loop, gap timer and issue counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cursor_q <= '0;
         mask_q   <= '0;
         loop_q   <= 1'b0;
         gap_q    <= '0;
         issued_q <= '0;
      end else begin
         state_q  <= state_d;
         cursor_q <= cursor_d;
         mask_q   <= mask_d;
         loop_q   <= loop_d;
         gap_q    <= gap_d;
         issued_q <= issued_d;
      end
   end

   // Next-state decode and Moore outputs.
   always_comb begin
      state_d   = state_q;
      cursor_d  = cursor_q;
      mask_d    = mask_q;
      loop_d    = loop_q;
      gap_d     = gap_q;
      issued_d  = issued_q;
      out_valid = (state_q == ST_OFFER);
      out_idx   = cursor_q;
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_FINISH);
      hs        = out_valid & out_ready;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mask_d = slot_en;
               loop_d = loop;
               if (first_found) begin
                  cursor_d = first_idx;
                  state_d  = ST_OFFER;
               end else begin
                  state_d  = ST_FINISH;
               end
            end
         end
         ST_OFFER: begin
            if (hs) begin
               issued_d = issued_q + CNT_W'(1);
               if (next_found && !stop) begin
                  cursor_d = next_idx;
                  gap_d    = GAP_LOAD;
                  state_d  = ST_GAP;
               end else if (loop_q && !stop) begin
                  // Captured mask is non-empty here, so first_idx is valid.
                  cursor_d = first_idx;
                  gap_d    = GAP_LOAD;
                  state_d  = ST_GAP;
               end else begin
                  state_d  = ST_FINISH;
               end
            end
         end
         ST_GAP: begin
            if (stop) begin
               state_d = ST_FINISH;
            end else if (gap_q == '0) begin
               state_d = ST_OFFER;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign issued_cnt = issued_q;

endmodule

// File: tb/tb_msg_slot_scheduler.sv
// Directed bench for msg_slot_scheduler (NUM_SLOTS=5, TICK_DIV=2).
module tb_msg_slot_scheduler;

   localparam int NUM_SLOTS = 5;
   localparam int IDX_W     = 3;
   localparam int TICK_DIV  = 2;
   localparam int CNT_W     = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 stop;
   logic                 loop;
   logic [NUM_SLOTS-1:0] slot_en;
   logic                 out_ready;
   logic                 out_valid;
   logic [IDX_W-1:0]     out_idx;
   logic                 busy;
   logic                 done;
   logic [CNT_W-1:0]     issued_cnt;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   msg_slot_scheduler #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W),
      .TICK_DIV  (TICK_DIV),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .loop       (loop),
      .slot_en    (slot_en),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_idx    (out_idx),
      .busy       (busy),
      .done       (done),
      .issued_cnt (issued_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_offer(input string tag, input int idx);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_idx"}, 32'(out_idx), 32'(idx));
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         if (done) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      loop      = 1'b0;
      slot_en   = '0;
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();

      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cnt", 32'(issued_cnt), 32'd0);

      // 1: all slots, no loop; mask change after start must be ignored
      slot_en = 5'b11111;
      start   = 1'b1;
      step();
      start   = 1'b0;
      slot_en = 5'b00000;
      check("t1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         check_offer("t1_offer", i);
         step();
         if (i < 4) begin
            check("t1_gap0", 32'(out_valid), 32'd0);
            step();
            check("t1_gap1", 32'(out_valid), 32'd0);
            step();
         end
      end
      check("t1_done", 32'(done), 32'd1);
      check("t1_fin_valid", 32'(out_valid), 32'd0);
      check("t1_fin_busy", 32'(busy), 32'd1);
      step();
      check("t1_done_clr", 32'(done), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);
      check("t1_cnt", 32'(issued_cnt), 32'd5);

      // 2: sparse mask, then empty mask
      slot_en = 5'b10010;
      start   = 1'b1;
      step();
      start   = 1'b0;
      check_offer("t2_first", 1);
      step();
      step();
      check("t2_gap", 32'(out_valid), 32'd0);
      step();
      check_offer("t2_second", 4);
      step();
      check("t2_done", 32'(done), 32'd1);
      step();
      check("t2_cnt", 32'(issued_cnt), 32'd7);
      slot_en = 5'b00000;
      start   = 1'b1;
      step();
      start   = 1'b0;
      check("t2e_valid", 32'(out_valid), 32'd0);
      check("t2e_done", 32'(done), 32'd1);
      step();
      check("t2e_done_clr", 32'(done), 32'd0);
      check("t2e_cnt", 32'(issued_cnt), 32'd7);

      // 3: back-pressure on idx 2
      slot_en = 5'b11111;
      start   = 1'b1;
      step();
      start   = 1'b0;
      check_offer("t3_s0", 0);
      step(); step(); step();
      check_offer("t3_s1", 1);
      step(); step(); step();
      out_ready = 1'b0;
      check_offer("t3_hold0", 2);
      step();
      check_offer("t3_hold1", 2);
      step();
      check_offer("t3_hold2", 2);
      step();
      out_ready = 1'b1;
      check_offer("t3_hold3", 2);
      check("t3_cnt_mid", 32'(issued_cnt), 32'd9);
      step();
      check("t3_gap", 32'(out_valid), 32'd0);
      check("t3_cnt_one", 32'(issued_cnt), 32'd10);
      wait_done("t3_done_seen", 20);
      step();
      check("t3_cnt", 32'(issued_cnt), 32'd12);

      // 4: loop over slots 0 and 2, stop during gap
      loop    = 1'b1;
      slot_en = 5'b00101;
      start   = 1'b1;
      step();
      start   = 1'b0;
      loop    = 1'b0;
      check_offer("t4_a", 0);
      step(); step(); step();
      check_offer("t4_b", 2);
      step(); step(); step();
      check_offer("t4_c", 0);
      step(); step(); step();
      check_offer("t4_d", 2);
      step();
      check("t4_gap", 32'(out_valid), 32'd0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t4_done", 32'(done), 32'd1);
      check("t4_no_offer", 32'(out_valid), 32'd0);
      step();
      check("t4_idle_valid", 32'(out_valid), 32'd0);
      check("t4_idle_busy", 32'(busy), 32'd0);
      check("t4_cnt", 32'(issued_cnt), 32'd16);

      // 5: stop while offering with sink stalled
      slot_en   = 5'b11111;
      out_ready = 1'b0;
      start     = 1'b1;
      step();
      start     = 1'b0;
      check_offer("t5_offer", 0);
      stop = 1'b1;
      step();
      check_offer("t5_hold0", 0);
      step();
      check_offer("t5_hold1", 0);
      out_ready = 1'b1;
      step();
      stop = 1'b0;
      check("t5_done", 32'(done), 32'd1);
      check("t5_valid", 32'(out_valid), 32'd0);
      check("t5_cnt", 32'(issued_cnt), 32'd17);
      step();
      check("t5_idle", 32'(busy), 32'd0);

      // 6: async reset mid-offer, then restart from slot 0
      slot_en = 5'b11111;
      start   = 1'b1;
      step();
      start   = 1'b0;
      step(); step(); step();
      check_offer("t6_pre", 1);
      #1;
      rst = 1'b1;
      #1;
      check("t6_valid", 32'(out_valid), 32'd0);
      check("t6_idx", 32'(out_idx), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_done", 32'(done), 32'd0);
      check("t6_cnt", 32'(issued_cnt), 32'd0);
      step();
      rst = 1'b0;
      step();
      check("t6_rst_done", 32'(done), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      check_offer("t6_restart", 0);
      check("t6_cnt_restart", 32'(issued_cnt), 32'd0);
      step();
      check("t6_cnt_after", 32'(issued_cnt), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
